arp_tx_engine: RTL and testbench
================================

# arp_tx_engine

Parametrised ARP frame generator that builds request and reply payloads for the MAC TX path. It sits between the ARP control logic, which raises reply triggers and active requests, and the MAC framing layer, which consumes the payload bytes. It provides the destination MAC for the Ethernet header. Compared with the previous generation it adds:
- `i_mac_ready` backpressure;
- queuing of triggers that arrive while a frame is in flight;
- reply-over-request priority;
- a correct target MAC/IP for replies;
- a parametrised frame length.

## Interface
- P_SRC_IP, {192,168,10,1}, local IP loaded at reset
- P_SRC_MAC, 48'h0, local MAC loaded at reset
- P_DST_IP, {192,168,10,0}, request target IP loaded at reset
- P_FRAME_LEN, 46, payload bytes per frame, legal range 28..1500; bytes 28..P_FRAME_LEN-1 are zero pad
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_src_ip / i_src_ip_valid  in  32/1  local IP update
- i_src_mac / i_src_mac_valid  in  48/1  local MAC update
- i_dst_ip / i_dst_ip_valid  in  32/1  request target IP update
- i_reply_req  in  1  one-cycle pulse: send a reply
- i_reply_mac / i_reply_ip  in  48/32  requester MAC/IP, sampled when i_reply_req=1
- i_active_req  in  1  one-cycle pulse: send a request
- o_mac_data  out  8  payload byte
- o_mac_valid  out  1  byte valid
- o_mac_last  out  1  final byte of frame, qualified by o_mac_valid
- i_mac_ready  in  1  sink accepts the byte when o_mac_valid & i_mac_ready
- o_dst_mac  out  48  Ethernet destination: FF..FF for a request, requester MAC for a reply; stable while o_mac_valid=1
- o_busy  out  1  1 when the FSM is not IDLE or a trigger is pending

## Operation
- Address registers:
  - Reset to the parameter values.
  - Each register loads when its valid strobe is high.
- Pending flags:
  - i_reply_req sets rep_pend and captures i_reply_mac/i_reply_ip into pending registers.
  - A new i_reply_req while rep_pend=1 overwrites the captured values (last requester wins).
  - i_active_req sets req_pend; repeated pulses merge.
  - Pulses are accepted in any state, including mid-frame.
- FSM has two states, IDLE and SEND.
- IDLE:
  - If rep_pend: clear rep_pend, op=2, THA/TPA=captured requester MAC/IP, o_dst_mac=requester MAC.
  - Otherwise, if req_pend: clear req_pend, op=1, THA=48'h0, TPA=dst_ip register, o_dst_mac=all-ones.
  - In both cases, snapshot src MAC/IP, zero the byte counter, go to SEND.
  - If a flag is set in the same cycle it is cleared, the set wins (the trigger stays pending).
- SEND:
  - Counter (11 bits) increments on each accepted beat.
  - On the beat where count = P_FRAME_LEN-1 is accepted, go to IDLE.
- Byte map by count:
  - 0-1: 00 01
  - 2-3: 08 00
  - 4: 06
  - 5: 04
  - 6-7: op, MSB first
  - 8-13: SHA
  - 14-17: SPA
  - 18-23: THA
  - 24-27: TPA
  - ≥28: 00
- Snapshot isolation: address updates or pulses during SEND do not alter the frame in flight.
- Backpressure: while o_mac_valid=1 and i_mac_ready=0, o_mac_data, o_mac_last and o_dst_mac hold their values.

## Timing
- Reset (async): o_mac_valid=0, o_mac_last=0, o_mac_data=0, o_dst_mac=0, o_busy=0. FSM returns to IDLE and pending flags clear.
- Reset mid-frame: outputs drop immediately and the frame is abandoned, not resumed.
- Latency: a pulse in cycle T sets the pending flag at edge T. The FSM enters SEND at edge T+1, and byte 0 is valid in cycle T+2.
- o_busy rises in cycle T+1.
- With i_mac_ready held at 1, a frame occupies exactly P_FRAME_LEN consecutive valid cycles.
- o_mac_last is high only during byte P_FRAME_LEN-1.
- After the last beat is accepted, o_mac_valid is low for at least one cycle (IDLE) before the next frame starts.
- If both triggers arrive in the same cycle, reply goes first, then request after the one-cycle gap.
- o_busy falls in the cycle after the last beat is accepted, provided no flag is pending.

## Test plan
- Request: reset, i_active_req pulse at cycle 10, ready=1 -> valid cycles 12..57 (46 bytes). Bytes 6-7=00 01; 18-23=00; 24-27=C0 A8 0A 00; 28-45=00. o_dst_mac=FFFFFFFFFFFF; last at cycle 57.
- Reply: i_reply_req with mac=0x112233445566, ip=192.168.10.7 -> op=00 02, bytes 18-23=11 22 33 44 55 66, 24-27=C0 A8 0A 07, o_dst_mac=0x112233445566.
- Simultaneous i_reply_req and i_active_req pulses -> reply frame, ≥1 idle cycle, then request frame. Exactly two frames total.
- Backpressure: i_mac_ready toggles 1,0,0,1 repeatedly -> every byte is held while stalled, no byte is lost or duplicated, and the captured stream is identical to the unstalled case.
- Mid-frame events: during a request, pulse i_src_ip_valid with 10.0.0.1 and pulse i_active_req -> the current frame keeps the old SPA. A second request follows with SPA=0A 00 00 01.
- Reset asserted at byte 20 -> o_mac_valid=0 within the same cycle, o_busy=0, and no frame after release without a new trigger. Repeat with P_FRAME_LEN=28 -> last on byte 27, no pad.

Source files
------------

// File: rtl/arp_tx_engine.sv
// arp_tx_engine
//   Builds ARP request/reply payloads (28-byte ARP body plus zero pad up to
//   P_FRAME_LEN bytes) for the MAC TX path, and supplies the Ethernet
//   destination MAC for the frame in flight.
//
// Ports
//   i_clk, i_rst                    clock, asynchronous active-high reset
//   i_src_ip/_valid                 local IP update (32)
//   i_src_mac/_valid                local MAC update (48)
//   i_dst_ip/_valid                 request target IP update (32)
//   i_reply_req                     pulse: send a reply
//   i_reply_mac, i_reply_ip         requester MAC/IP, sampled with i_reply_req
//   i_active_req                    pulse: send a request
//   o_mac_data/_valid/_last         payload byte stream
//   i_mac_ready                     sink accepts a byte on valid & ready
//   o_dst_mac                       Ethernet destination for the current frame
//   o_busy                          frame in flight or trigger pending
module arp_tx_engine #(
  parameter logic [31:0] P_SRC_IP    = {8'd192, 8'd168, 8'd10, 8'd1},
  parameter logic [47:0] P_SRC_MAC   = 48'h0,
  parameter logic [31:0] P_DST_IP    = {8'd192, 8'd168, 8'd10, 8'd0},
  parameter int          P_FRAME_LEN = 46
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_src_ip,
  input  logic        i_src_ip_valid,
  input  logic [47:0] i_src_mac,
  input  logic        i_src_mac_valid,
  input  logic [31:0] i_dst_ip,
  input  logic        i_dst_ip_valid,
  input  logic        i_reply_req,
  input  logic [47:0] i_reply_mac,
  input  logic [31:0] i_reply_ip,
  input  logic        i_active_req,
  output logic [7:0]  o_mac_data,
  output logic        o_mac_valid,
  output logic        o_mac_last,
  input  logic        i_mac_ready,
  output logic [47:0] o_dst_mac,
  output logic        o_busy
);

  localparam logic [10:0] LP_LAST = 11'(P_FRAME_LEN - 1);

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  state_t      r_state;
  logic        r_rep_pend;
  logic        r_req_pend;
  logic [10:0] r_cnt;

  // Address registers
  logic [31:0] r_src_ip;
  logic [47:0] r_src_mac;
  logic [31:0] r_dst_ip;

  // Captured requester (last requester wins)
  logic [47:0] r_rep_mac;
  logic [31:0] r_rep_ip;

  // Per-frame snapshot, frozen for the whole frame
  logic [15:0] r_op;
  logic [47:0] r_sha;
  logic [31:0] r_spa;
  logic [47:0] r_tha;
  logic [31:0] r_tpa;

  // Registered outputs
  logic [7:0]  r_mac_data;
  logic        r_mac_valid;
  logic        r_mac_last;
  logic [47:0] r_dst_mac;

  logic        w_start;
  logic        w_accept;
  logic [10:0] w_next_cnt;

  // Payload byte at a given offset of the frame.
  function automatic logic [7:0] f_byte(
    input logic [10:0] idx,
    input logic [15:0] op,
    input logic [47:0] sha,
    input logic [31:0] spa,
    input logic [47:0] tha,
    input logic [31:0] tpa
  );
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      11'd0:   b = 8'h00;           // HTYPE = Ethernet
      11'd1:   b = 8'h01;
      11'd2:   b = 8'h08;           // PTYPE = IPv4
      11'd3:   b = 8'h00;
      11'd4:   b = 8'h06;           // HLEN
      11'd5:   b = 8'h04;           // PLEN
      11'd6:   b = op[15:8];
      11'd7:   b = op[7:0];
      11'd8:   b = sha[47:40];
      11'd9:   b = sha[39:32];
      11'd10:  b = sha[31:24];
      11'd11:  b = sha[23:16];
      11'd12:  b = sha[15:8];
      11'd13:  b = sha[7:0];
      11'd14:  b = spa[31:24];
      11'd15:  b = spa[23:16];
      11'd16:  b = spa[15:8];
      11'd17:  b = spa[7:0];
      11'd18:  b = tha[47:40];
      11'd19:  b = tha[39:32];
      11'd20:  b = tha[31:24];
      11'd21:  b = tha[23:16];
      11'd22:  b = tha[15:8];
      11'd23:  b = tha[7:0];
      11'd24:  b = tpa[31:24];
      11'd25:  b = tpa[23:16];
      11'd26:  b = tpa[15:8];
      11'd27:  b = tpa[7:0];
      default: b = 8'h00;           // zero pad
    endcase
    return b;
  endfunction

  assign w_start    = (r_state == ST_IDLE) && (r_rep_pend || r_req_pend);
  assign w_accept   = r_mac_valid && i_mac_ready;
  assign w_next_cnt = r_cnt + 11'd1;

  // Control, address registers and output stage
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_rep_pend  <= 1'b0;
      r_req_pend  <= 1'b0;
      r_cnt       <= 11'd0;
      r_src_ip    <= P_SRC_IP;
      r_src_mac   <= P_SRC_MAC;
      r_dst_ip    <= P_DST_IP;
      r_mac_data  <= 8'h00;
      r_mac_valid <= 1'b0;
      r_mac_last  <= 1'b0;
      r_dst_mac   <= 48'h0;
    end else begin
      if (i_src_ip_valid)  r_src_ip  <= i_src_ip;
      if (i_src_mac_valid) r_src_mac <= i_src_mac;
      if (i_dst_ip_valid)  r_dst_ip  <= i_dst_ip;

      // A new pulse in the same cycle as the clear keeps the trigger pending.
      if (i_reply_req)
        r_rep_pend <= 1'b1;
      else if (w_start && r_rep_pend)
        r_rep_pend <= 1'b0;

      if (i_active_req)
        r_req_pend <= 1'b1;
      else if (w_start && !r_rep_pend)
        r_req_pend <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state     <= ST_SEND;
            r_cnt       <= 11'd0;
            r_mac_valid <= 1'b1;
            r_mac_data  <= 8'h00;
            r_mac_last  <= 1'b0;
            r_dst_mac   <= r_rep_pend ? r_rep_mac : 48'hFFFF_FFFF_FFFF;
          end
        end
        ST_SEND: begin
          // Everything holds while the sink stalls.
          if (w_accept) begin
            if (r_cnt == LP_LAST) begin
              r_state     <= ST_IDLE;
              r_mac_valid <= 1'b0;
              r_mac_last  <= 1'b0;
            end else begin
              r_cnt      <= w_next_cnt;
              r_mac_data <= f_byte(w_next_cnt, r_op, r_sha, r_spa, r_tha, r_tpa);
              r_mac_last <= (w_next_cnt == LP_LAST);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Requester capture and frame snapshot (data only, no reset needed)
  always_ff @(posedge i_clk) begin
    if (i_reply_req) begin
      r_rep_mac <= i_reply_mac;
      r_rep_ip  <= i_reply_ip;
    end
    if (w_start) begin
      r_sha <= r_src_mac;
      r_spa <= r_src_ip;
      if (r_rep_pend) begin
        r_op  <= 16'h0002;
        r_tha <= r_rep_mac;
        r_tpa <= r_rep_ip;
      end else begin
        r_op  <= 16'h0001;
        r_tha <= 48'h0;
        r_tpa <= r_dst_ip;
      end
    end
  end

  assign o_mac_data  = r_mac_data;
  assign o_mac_valid = r_mac_valid;
  assign o_mac_last  = r_mac_last;
  assign o_dst_mac   = r_dst_mac;
  assign o_busy      = (r_state != ST_IDLE) || r_rep_pend || r_req_pend;

endmodule

// File: tb/tb_arp_tx_engine.sv
module tb_arp_tx_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] src_ip;
  logic        src_ip_v;
  logic [47:0] src_mac;
  logic        src_mac_v;
  logic [31:0] dst_ip;
  logic        dst_ip_v;
  logic        rep_req;
  logic [47:0] rep_mac;
  logic [31:0] rep_ip;
  logic        act_req;
  logic        ready;

  logic [7:0]  d0_data, d1_data;
  logic        d0_valid, d1_valid, d0_last, d1_last, d0_busy, d1_busy;
  logic [47:0] d0_dst, d1_dst;

  logic [7:0]  m_data  [2];
  logic        m_valid [2];
  logic        m_last  [2];
  logic        m_busy  [2];
  logic [47:0] m_dst   [2];

  assign m_data[0] = d0_data;   assign m_data[1] = d1_data;
  assign m_valid[0] = d0_valid; assign m_valid[1] = d1_valid;
  assign m_last[0] = d0_last;   assign m_last[1] = d1_last;
  assign m_busy[0] = d0_busy;   assign m_busy[1] = d1_busy;
  assign m_dst[0] = d0_dst;     assign m_dst[1] = d1_dst;

  arp_tx_engine u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_src_ip(src_ip), .i_src_ip_valid(src_ip_v),
    .i_src_mac(src_mac), .i_src_mac_valid(src_mac_v),
    .i_dst_ip(dst_ip), .i_dst_ip_valid(dst_ip_v),
    .i_reply_req(rep_req), .i_reply_mac(rep_mac), .i_reply_ip(rep_ip),
    .i_active_req(act_req),
    .o_mac_data(d0_data), .o_mac_valid(d0_valid), .o_mac_last(d0_last),
    .i_mac_ready(ready), .o_dst_mac(d0_dst), .o_busy(d0_busy)
  );

  arp_tx_engine #(.P_FRAME_LEN(28)) u_dut28 (
    .i_clk(clk), .i_rst(rst),
    .i_src_ip(src_ip), .i_src_ip_valid(src_ip_v),
    .i_src_mac(src_mac), .i_src_mac_valid(src_mac_v),
    .i_dst_ip(dst_ip), .i_dst_ip_valid(dst_ip_v),
    .i_reply_req(rep_req), .i_reply_mac(rep_mac), .i_reply_ip(rep_ip),
    .i_active_req(act_req),
    .o_mac_data(d1_data), .o_mac_valid(d1_valid), .o_mac_last(d1_last),
    .i_mac_ready(ready), .o_dst_mac(d1_dst), .o_busy(d1_busy)
  );

  typedef struct packed {
    logic [15:0] op;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [47:0] tha;
    logic [31:0] tpa;
    logic [47:0] dst;
  } frm_t;

  frm_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Per-instance monitor state
  int          lens [2] = '{46, 28};
  int          rd   [2] = '{0, 0};
  int          idx  [2] = '{0, 0};
  bit          in_frame [2] = '{1'b0, 1'b0};
  bit          pl   [2] = '{1'b0, 1'b0};
  bit          stall[2] = '{1'b0, 1'b0};
  logic [56:0] held [2];
  frm_t        cur  [2];

  bit bp_mode = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input frm_t f, input int i);
    logic [223:0] hdr;
    hdr = {16'h0001, 16'h0800, 8'h06, 8'h04, f.op, f.sha, f.spa, f.tha, f.tpa};
    if (i >= 28) return 8'h00;
    return hdr[223 - 8*i -: 8];
  endfunction

  task automatic push(input logic [15:0] op, input logic [47:0] sha, input logic [31:0] spa,
                      input logic [47:0] tha, input logic [31:0] tpa, input logic [47:0] dst);
    frm_t f;
    f.op = op; f.sha = sha; f.spa = spa; f.tha = tha; f.tpa = tpa; f.dst = dst;
    exp_q.push_back(f);
  endtask

  task automatic mon_step(input int k);
    logic [56:0] obs;
    obs = {m_data[k], m_last[k], m_dst[k]};
    if (rst) begin
      in_frame[k] = 1'b0; pl[k] = 1'b0; stall[k] = 1'b0;
      rd[k] = exp_q.size();
      return;
    end
    if (stall[k])
      chk($sformatf("hold_u%0d_b%0d", k, idx[k]), 64'({m_valid[k], obs}), 64'({1'b1, held[k]}));
    stall[k] = 1'b0;
    if (pl[k])
      chk($sformatf("gap_u%0d", k), 64'(m_valid[k]), 64'(0));
    pl[k] = 1'b0;
    if (!m_valid[k]) return;
    if (!in_frame[k]) begin
      if (rd[k] >= exp_q.size()) begin
        chk($sformatf("unexpected_beat_u%0d", k), 64'(m_valid[k]), 64'(0));
        return;
      end
      cur[k] = exp_q[rd[k]];
      rd[k]++;
      in_frame[k] = 1'b1;
      idx[k] = 0;
    end
    chk($sformatf("beat_u%0d_b%0d(data,last,dst)", k, idx[k]), 64'(obs),
        64'({exp_byte(cur[k], idx[k]), (idx[k] == lens[k] - 1), cur[k].dst}));
    if (ready) begin
      if (idx[k] == lens[k] - 1) begin
        in_frame[k] = 1'b0;
        pl[k] = 1'b1;
      end else begin
        idx[k]++;
      end
    end else begin
      stall[k] = 1'b1;
      held[k] = obs;
    end
  endtask

  // Monitor: checks every presented beat against the scoreboard queue.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) mon_step(k);
    end
  end

  // Ready driver: 1,0,0,1 pattern in backpressure mode.
  initial begin
    int ph;
    ph = 0;
    ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready = bp_mode ? ((ph == 0) || (ph == 3)) : 1'b1;
      ph = (ph + 1) % 4;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #3;
      if (rd[0] == exp_q.size() && rd[1] == exp_q.size() && !in_frame[0] && !in_frame[1] &&
          !m_busy[0] && !m_busy[1]) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_completed"}, 64'(ok), 64'(1));
  endtask

  initial begin
    int nv0, nv1;
    rst = 1'b1;
    src_ip = '0; src_ip_v = 1'b0; src_mac = '0; src_mac_v = 1'b0;
    dst_ip = '0; dst_ip_v = 1'b0; rep_req = 1'b0; rep_mac = '0; rep_ip = '0; act_req = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_u0", 64'({d0_valid, d0_last, d0_data, d0_dst, d0_busy}), 64'(0));
    chk("reset_u1", 64'({d1_valid, d1_last, d1_data, d1_dst, d1_busy}), 64'(0));
    tick();
    rst = 1'b0;
    repeat (6) tick();

    // Request with reset-default addresses
    push(16'h0001, 48'h0, 32'hC0A8_0A01, 48'h0, 32'hC0A8_0A00, 48'hFFFF_FFFF_FFFF);
    act_req = 1'b1;
    @(posedge clk); #1;
    act_req = 1'b0;
    @(negedge clk);
    chk("busy_T+1", 64'({d0_busy, d1_busy}), 64'(2'b11));
    chk("valid_T+1", 64'({d0_valid, d1_valid}), 64'(2'b00));
    @(negedge clk);
    chk("valid_T+2", 64'({d0_valid, d1_valid}), 64'(2'b11));
    nv0 = 1; nv1 = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      nv0 += int'(d0_valid);
      nv1 += int'(d1_valid);
    end
    chk("req_len_46", 64'(nv0), 64'(46));
    chk("req_len_28", 64'(nv1), 64'(28));
    wait_idle("request", 100);

    // Reply with a non-zero local MAC
    src_mac = 48'h0200_5EAA_BBCC; src_mac_v = 1'b1;
    tick();
    src_mac_v = 1'b0;
    push(16'h0002, 48'h0200_5EAA_BBCC, 32'hC0A8_0A01, 48'h1122_3344_5566, 32'hC0A8_0A07,
         48'h1122_3344_5566);
    rep_mac = 48'h1122_3344_5566; rep_ip = 32'hC0A8_0A07; rep_req = 1'b1;
    tick();
    rep_req = 1'b0;
    wait_idle("reply", 120);

    // Simultaneous reply + request: reply first, then request
    push(16'h0002, 48'h0200_5EAA_BBCC, 32'hC0A8_0A01, 48'hAABB_CCDD_EEFF, 32'hC0A8_0A63,
         48'hAABB_CCDD_EEFF);
    push(16'h0001, 48'h0200_5EAA_BBCC, 32'hC0A8_0A01, 48'h0, 32'hC0A8_0A00, 48'hFFFF_FFFF_FFFF);
    rep_mac = 48'hAABB_CCDD_EEFF; rep_ip = 32'hC0A8_0A63; rep_req = 1'b1; act_req = 1'b1;
    tick();
    rep_req = 1'b0; act_req = 1'b0;
    wait_idle("simultaneous", 200);

    // Backpressure 1,0,0,1 over a reply and a request
    bp_mode = 1'b1;
    push(16'h0002, 48'h0200_5EAA_BBCC, 32'hC0A8_0A01, 48'h6655_4433_2211, 32'hC0A8_0A22,
         48'h6655_4433_2211);
    push(16'h0001, 48'h0200_5EAA_BBCC, 32'hC0A8_0A01, 48'h0, 32'hC0A8_0A00, 48'hFFFF_FFFF_FFFF);
    rep_mac = 48'h6655_4433_2211; rep_ip = 32'hC0A8_0A22; rep_req = 1'b1; act_req = 1'b1;
    tick();
    rep_req = 1'b0; act_req = 1'b0;
    wait_idle("backpressure", 500);
    bp_mode = 1'b0;
    repeat (4) tick();

    // Mid-frame address updates and a new request
    push(16'h0001, 48'h0200_5EAA_BBCC, 32'hC0A8_0A01, 48'h0, 32'hC0A8_0A00, 48'hFFFF_FFFF_FFFF);
    act_req = 1'b1;
    tick();
    act_req = 1'b0;
    repeat (10) tick();
    push(16'h0001, 48'h0200_5EAA_BBCC, 32'h0A00_0001, 48'h0, 32'hC0A8_0A05, 48'hFFFF_FFFF_FFFF);
    src_ip = 32'h0A00_0001; src_ip_v = 1'b1;
    dst_ip = 32'hC0A8_0A05; dst_ip_v = 1'b1;
    act_req = 1'b1;
    tick();
    src_ip_v = 1'b0; dst_ip_v = 1'b0; act_req = 1'b0;
    wait_idle("midframe", 200);

    // Reset asserted while byte 20 is presented
    push(16'h0001, 48'h0200_5EAA_BBCC, 32'h0A00_0001, 48'h0, 32'hC0A8_0A05, 48'hFFFF_FFFF_FFFF);
    act_req = 1'b1;
    @(posedge clk); #1;
    act_req = 1'b0;
    repeat (21) @(posedge clk);
    #1;
    chk("valid_before_rst", 64'({d0_valid, d1_valid}), 64'(2'b11));
    chk("byte20_before_rst", 64'({d0_data, d1_data}), 64'(16'h0000));
    #1;
    rst = 1'b1;
    #1;
    chk("valid_in_rst", 64'({d0_valid, d1_valid}), 64'(2'b00));
    chk("busy_in_rst", 64'({d0_busy, d1_busy}), 64'(2'b00));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (70) tick();
    chk("busy_after_rst", 64'({d0_busy, d1_busy}), 64'(2'b00));

    // Recovery: addresses back at their reset values
    push(16'h0001, 48'h0, 32'hC0A8_0A01, 48'h0, 32'hC0A8_0A00, 48'hFFFF_FFFF_FFFF);
    act_req = 1'b1;
    tick();
    act_req = 1'b0;
    wait_idle("recovery", 100);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
